// File: rtl/fp_regfile_sb_if.sv
// Bus bundle for the FP register file: two read ports, one write port,
// the issue/scoreboard handshake and the pending-count status.
interface fp_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // read port 1
  logic [ADDR_W-1:0]   rd_addr1;
  logic                rd_dp1;
  logic [2*DATA_W-1:0] rd_data1;
  logic                rd_busy1;

  // read port 2
  logic [ADDR_W-1:0]   rd_addr2;
  logic                rd_dp2;
  logic [2*DATA_W-1:0] rd_data2;
  logic                rd_busy2;

  // write port
  logic                wr_en;
  logic                wr_dp;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0] wr_data;

  // issue / scoreboard
  logic                iss_valid;
  logic                iss_dp;
  logic [ADDR_W-1:0]   iss_addr;
  logic                iss_ready;

  // status
  logic [ADDR_W:0]     pend_cnt;
  logic                all_idle;

  // decode / writeback side
  modport master (
    output rd_addr1, rd_dp1, rd_addr2, rd_dp2,
    output wr_en, wr_dp, wr_addr, wr_data,
    output iss_valid, iss_dp, iss_addr,
    input  rd_data1, rd_busy1, rd_data2, rd_busy2,
    input  iss_ready, pend_cnt, all_idle
  );

  // register file side
  modport slave (
    input  rd_addr1, rd_dp1, rd_addr2, rd_dp2,
    input  wr_en, wr_dp, wr_addr, wr_data,
    input  iss_valid, iss_dp, iss_addr,
    output rd_data1, rd_busy1, rd_data2, rd_busy2,
    output iss_ready, pend_cnt, all_idle
  );

endinterface

// File: rtl/fp_regfile_sb.sv
// Floating-point register file with pending-write scoreboard.
// Two combinational read ports and one synchronous write port, each in
// single or even/odd pair mode. Same-cycle writes forward to the reads,
// and per-register busy bits track results still in flight so decode can
// stall on RAW (rd_busy*) and WAW (iss_ready) hazards.
module fp_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  fp_regfile_sb_if.slave     bus
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    pend_cnt_q;
  logic [CNT_W-1:0]    pend_cnt_d;

  logic [NUM_REGS-1:0] wr_mask;
  logic [DATA_W-1:0]   wr_val [NUM_REGS];
  logic [NUM_REGS-1:0] iss_mask;
  logic                iss_fire;

  logic [ADDR_W-1:0]   rd1_lo_idx;
  logic [ADDR_W-1:0]   rd1_hi_idx;
  logic [ADDR_W-1:0]   rd2_lo_idx;
  logic [ADDR_W-1:0]   rd2_hi_idx;

  // Per-register decode of the write and issue requests. In pair mode the
  // address LSB is dropped, and the odd member takes the high data half.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);

    assign wr_mask[g] = bus.wr_en &
                        (bus.wr_dp ? (bus.wr_addr[ADDR_W-1:1] == IDX[ADDR_W-1:1])
                                   : (bus.wr_addr == IDX));

    assign wr_val[g] = (bus.wr_dp && IDX[0]) ? bus.wr_data[2*DATA_W-1:DATA_W]
                                             : bus.wr_data[DATA_W-1:0];

    assign iss_mask[g] = bus.iss_valid &
                         (bus.iss_dp ? (bus.iss_addr[ADDR_W-1:1] == IDX[ADDR_W-1:1])
                                     : (bus.iss_addr == IDX));
  end

  // Next register contents. This is also the forwarded view the read ports
  // use, so write-through bypass falls out per register (and per half).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr_mask[i] ? wr_val[i] : regs_q[i];
    end
  end

  // Register storage update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Issue acceptance: stall only on a destination that is busy and is not
  // being retired by a writeback this same cycle.
  always_comb begin
    bus.iss_ready = bus.iss_valid & ~|(iss_mask & busy_q & ~wr_mask);
    iss_fire      = bus.iss_valid & bus.iss_ready;
  end

  // Busy bits: writes clear, accepted issues set; set wins on overlap.
  always_comb begin
    busy_d = busy_q & ~wr_mask;
    if (iss_fire) begin
      busy_d = busy_d | iss_mask;
    end
  end

  // Population count of the next busy vector, so pend_cnt always matches
  // the registered busy bits and can never wrap.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Scoreboard state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Read port 1: low half is the addressed/even register, high half is the
  // odd partner in pair mode and zero in single mode.
  always_comb begin
    rd1_lo_idx   = bus.rd_dp1 ? {bus.rd_addr1[ADDR_W-1:1], 1'b0} : bus.rd_addr1;
    rd1_hi_idx   = {bus.rd_addr1[ADDR_W-1:1], 1'b1};
    bus.rd_data1 = {(bus.rd_dp1 ? regs_d[rd1_hi_idx] : {DATA_W{1'b0}}),
                    regs_d[rd1_lo_idx]};
    bus.rd_busy1 = busy_q[rd1_lo_idx] | (bus.rd_dp1 & busy_q[rd1_hi_idx]);
  end

  // Read port 2, same structure as port 1.
  always_comb begin
    rd2_lo_idx   = bus.rd_dp2 ? {bus.rd_addr2[ADDR_W-1:1], 1'b0} : bus.rd_addr2;
    rd2_hi_idx   = {bus.rd_addr2[ADDR_W-1:1], 1'b1};
    bus.rd_data2 = {(bus.rd_dp2 ? regs_d[rd2_hi_idx] : {DATA_W{1'b0}}),
                    regs_d[rd2_lo_idx]};
    bus.rd_busy2 = busy_q[rd2_lo_idx] | (bus.rd_dp2 & busy_q[rd2_hi_idx]);
  end

  // Status outputs.
  always_comb begin
    bus.pend_cnt = pend_cnt_q;
    bus.all_idle = (pend_cnt_q == '0);
  end

endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
Parametrised floating-point register file with a pending-write scoreboard, for the IITK-Mini-MIPS FPU datapath. It provides two asynchronous read ports and one synchronous write port, each able to operate in single-precision mode or in double-precision even/odd register-pair mode. Write-through bypass lets a read see a write in the same cycle. Per-register busy bits track results still in flight from multicycle FPU operations, so decode can stall on RAW and WAW hazards.

Parameters:
DATA_W, 32, width of one FPR in bits
NUM_REGS, 32, number of FPRs; must be even and a power of two
ADDR_W, 5, register address width; equals log2(NUM_REGS)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
rd_addr1  input  ADDR_W  read port 1 address
rd_dp1  input  1  read port 1 pair mode
rd_data1  output  2*DATA_W  read port 1 data
rd_busy1  output  1  addressed register(s) have a write pending
rd_addr2  input  ADDR_W  read port 2 address
rd_dp2  input  1  read port 2 pair mode
rd_data2  output  2*DATA_W  read port 2 data
rd_busy2  output  1  addressed register(s) have a write pending
wr_en  input  1  write enable
wr_dp  input  1  write pair mode
wr_addr  input  ADDR_W  write address
wr_data  input  2*DATA_W  write data
iss_valid  input  1  issue request: mark the destination busy
iss_dp  input  1  issue destination is a register pair
iss_addr  input  ADDR_W  issue destination address
iss_ready  output  1  issue accepted this cycle
pend_cnt  output  ADDR_W+1  number of busy registers
all_idle  output  1  pend_cnt == 0

Behaviour:
- Reset (asynchronous, rst=1): all registers cleared to 0; all busy bits cleared. While in reset: pend_cnt=0, all_idle=1, rd_busy*=0, rd_data* read as 0 except where the same-cycle bypass applies.
- Pair addressing: when a dp flag is set, the address LSB is ignored. Even index e = addr with LSB cleared; the pair is {reg[e+1], reg[e]}, with reg[e] in the low half.
- Read (combinational, zero latency):
  - Single mode: rd_data = {DATA_W zeros, reg[addr]}.
  - Pair mode: rd_data = {reg[e+1], reg[e]}.
- Write-through bypass: each read half whose register index matches a register being written this cycle (wr_en=1) returns the corresponding wr_data half instead of the stored value.
  - A single write to addr uses wr_data[DATA_W-1:0].
  - A pair write drives reg[e] from the low half and reg[e+1] from the high half.
  - The bypass applies per half, so mixed single/pair overlaps forward correctly.
- Write (synchronous): on the rising edge with wr_en=1, update reg[wr_addr] (single mode) or reg[e] and reg[e+1] (pair mode). Every write clears the busy bit of each register it writes, whether or not that bit was set.
- rd_busy: OR of the busy bits of the addressed register(s), i.e. one register in single mode, two in pair mode. Reflects registered state only; no bypass from the same-cycle writeback.
- iss_ready (combinational): 1 when iss_valid=1 and every destination register is either not busy or being written this cycle. Otherwise 0, which signals a WAW stall.
- Issue: on the rising edge with iss_valid & iss_ready, set the destination busy bit(s).
- Same-cycle writeback and issue to the same register: the set wins, so the busy bit ends at 1 and the register data updates.
- pend_cnt: registered population count of the busy bits, updated on each edge (+set, −cleared, net); never wraps. all_idle = (pend_cnt == 0).

Test Plan:
- Reset, then write reg3=0x3F800000 in single mode; the next cycle, read port 1 at addr 3 → rd_data1=0x00000000_3F800000. Read port 2 at addr 4 → 0.
- Pair write at addr 7 (treated as 6) with 0x40090000_00000000; read addr 6 in pair mode → 0x40090000_00000000. Single read of addr 7 → 0x40090000.
- Bypass: in the same cycle as a write of 0xDEADBEEF to reg5, read addr 5 → 0xDEADBEEF that cycle. Pair read of addr 4 → {reg5 bypass, reg4 stored}.
- Scoreboard: issue reg8 → next cycle rd_busy1=1, pend_cnt=1. A second issue to reg8 → iss_ready=0. Writeback to reg8 together with a re-issue → iss_ready=1, busy stays 1, pend_cnt stays 1.
- Pair issue at addr 10 → pend_cnt=2. Single writeback to reg11 → pend_cnt=1; pair rd_busy at addr 10 is still 1 until reg10 is written.
- Assert rst mid-operation with 3 busy registers and nonzero data → immediately pend_cnt=0, all_idle=1, all reads 0.
